mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: cycles busy stays high for a multiply-class op.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: cycles busy stays high for a divide-class op.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: accept op this cycle.
REQ-006 SHALL have port op, input, 4 bits: operation code; encodings in REQ-038.
REQ-007 SHALL have port srcA, input, 32 bits: rs operand from the register-file read port 1.
REQ-008 SHALL have port srcB, input, 32 bits: rt operand from the register-file read port 2.
REQ-009 SHALL have port busy, output, 1 bit: operation in flight.
REQ-010 SHALL have port hi, output, 32 bits: committed HI register; feeds the mfhi writeback to the register file.
REQ-011 SHALL have port lo, output, 32 bits: committed LO register; feeds the mflo writeback to the register file.

Function
REQ-012 SHALL accept an op only when start=1, busy=0 and reset=0; start while busy SHALL be ignored with no state change.
REQ-013 MULT/MULTU accepted at edge t SHALL raise busy for cycles t+1..t+MULT_CYCLES; {hi,lo} SHALL equal the 64-bit signed/unsigned product from the edge that drops busy.
REQ-014 DIV/DIVU accepted at edge t SHALL raise busy for cycles t+1..t+DIV_CYCLES; lo=quotient, hi=remainder committed at the busy-falling edge.
REQ-015 Signed divide SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-016 0x80000000 DIV 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000.
REQ-017 Divide by zero SHALL still hold busy for DIV_CYCLES and SHALL leave hi/lo unchanged.
REQ-018 MTHI/MTLO SHALL write srcA into hi/lo at the accepting edge, visible next cycle; busy SHALL stay 0.
REQ-019 Operands SHALL be latched at acceptance; srcA/srcB changes while busy SHALL have no effect.
REQ-020 hi/lo SHALL hold their old values during busy; only the final edge updates them.
REQ-021 The down-counter SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES); busy = (counter != 0).
REQ-022 Op NONE or unknown codes SHALL cause no state change.
REQ-023 A new op SHALL be accepted in the cycle after busy falls; it SHALL NOT be accepted on the same edge busy falls.

Reset
REQ-024 reset=1 at a rising edge SHALL set hi=0, lo=0, counter=0 and busy=0.
REQ-025 reset SHALL take priority over start and SHALL discard any in-flight result.
REQ-026 After reset, no commit from an aborted op SHALL ever occur.

Configuration
REQ-027 Macro MDU_MADD_EN SHALL control the accumulate ops MADD, MADDU, MSUB and MSUBU.
REQ-028 With MDU_MADD_EN defined: {hi,lo} +/- (signed/unsigned srcA*srcB), modulo 2^64, latency MULT_CYCLES.
REQ-029 The accumulate SHALL use the {hi,lo} value present at acceptance.
REQ-030 Without MDU_MADD_EN: opcodes 7-10 SHALL be treated as NONE, with busy staying 0 and no state change.

Structure
REQ-031 Op encodings SHALL live in the shared CPU definitions header, shared with the decoder and stall unit.
REQ-032 Default latency constants SHALL live in the same shared header.
REQ-033 The result SHALL be computed combinationally at acceptance into shadow registers; the counter SHALL model the latency.
REQ-034 The block SHALL have no sub-module.
REQ-035 The counter/commit control SHALL be a two-state IDLE/BUSY machine.
REQ-036 IDLE SHALL go to BUSY on an accepted mult- or div-class op.
REQ-037 BUSY SHALL go to IDLE when counter==1, committing the shadow registers to hi/lo at that edge.
REQ-038 Op encodings SHALL be: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.

Verification
REQ-039 MULT -3 x 5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-040 MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-041 DIV -7 / 2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-042 DIV x / 0 with prior MTHI 0x1234, MTLO 0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 retained.
REQ-043 DIVU 100 / 7 with reset asserted in busy cycle 4 -> next cycle busy=0, hi=lo=0; no later commit.
REQ-044 MULT started, MTLO 0x1 presented during busy -> ignored; MADD 2 x 3 after {hi,lo}=0x0_0000000A -> lo=0x10 (only with MDU_MADD_EN).

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings used by
// the decoder, the stall unit and the MDU, plus the default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. The result is computed at
// acceptance into shadow registers; a down-counter models the latency and
// the shadow value is committed on the edge that drops busy.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = max_u(MULT_CYCLES, DIV_CYCLES);
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

    logic        is_mul, is_div, is_acc, is_sub, is_sgn;
    logic [63:0] mul_a, mul_b, prod, acc, mul_res;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

    // Decode the op code into operation classes; unknown codes decode to nothing.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_acc = 1'b0;
        is_sub = 1'b0;
        is_sgn = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            OP_MULTU: begin is_mul = 1'b1; end
            OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            OP_DIVU:  begin is_div = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; is_sgn = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_sgn = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Multiply (optionally accumulating into {hi,lo}) and sign-magnitude divide.
    // Dividing magnitudes makes 0x80000000 / -1 fall out naturally as 0x80000000.
    always_comb begin
        mul_a   = {{32{is_sgn & srcA[31]}}, srcA};
        mul_b   = {{32{is_sgn & srcB[31]}}, srcB};
        prod    = mul_a * mul_b;
        acc     = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        mul_res = is_acc ? acc : prod;

        neg_a = is_sgn & srcA[31];
        neg_b = is_sgn & srcB[31];
        mag_a = neg_a ? (~srcA + 32'd1) : srcA;
        mag_b = neg_b ? (~srcB + 32'd1) : srcB;
        uq    = (mag_b == '0) ? '0 : (mag_a / mag_b);
        ur    = (mag_b == '0) ? '0 : (mag_a % mag_b);
        quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem   = neg_a ? (~ur + 32'd1) : ur;
    end

    // IDLE/BUSY control: accept ops in IDLE, count down in BUSY, commit on the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d            = ST_BUSY;
                        cnt_d              = CW'(MULT_CYCLES);
                        {sh_hi_d, sh_lo_d} = mul_res;
                    end else if (is_div) begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(DIV_CYCLES);
                        // divide by zero commits the current hi/lo back unchanged
                        sh_hi_d = (srcB == '0) ? hi_q : rem;
                        sh_lo_d = (srcB == '0) ? lo_q : quo;
                    end else if (op == OP_MTHI) begin
                        hi_d = srcA;
                    end else if (op == OP_MTLO) begin
                        lo_d = srcA;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed cases plus randomized traffic checked against
// an arithmetic reference model kept in the bench.
module tb_mdu;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_rem = 0;
    logic        m_commit = 1'b0;
    logic [63:0] m_pend = '0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .srcA (srcA),
        .srcB (srcB),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic madd_en();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Architectural effect of one clock edge given the inputs presented.
    task automatic model_edge(input logic rst, input logic st, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] p, q64, r64;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_commit = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_commit) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (st) begin
            case (o)
                4'd1: begin p = sa * sb; m_pend = p; m_commit = 1'b1; m_rem = MC; end
                4'd2: begin p = ua * ub; m_pend = p; m_commit = 1'b1; m_rem = MC; end
                4'd3, 4'd4: begin
                    m_rem = DC;
                    m_commit = (b != 0);
                    if (b != 0) begin
                        if (o == 4'd3) begin sq = sa / sb; sr = sa % sb; end
                        else begin sq = longint'(ua / ub); sr = longint'(ua % ub); end
                        q64 = sq; r64 = sr;
                        m_pend = {r64[31:0], q64[31:0]};
                    end
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                4'd7, 4'd8, 4'd9, 4'd10: begin
                    if (madd_en()) begin
                        p = (o == 4'd7 || o == 4'd9) ? 64'(sa * sb) : 64'(ua * ub);
                        m_pend = (o >= 4'd9) ? ({m_hi, m_lo} - p) : ({m_hi, m_lo} + p);
                        m_commit = 1'b1;
                        m_rem = MC;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        reset = rst; start = st; op = o; srcA = a; srcB = b;
        @(posedge clk);
        model_edge(rst, st, o, a, b);
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, m_rem != 0});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset
        cycle(1'b1, 1'b0, 4'd0, '0, '0);
        cycle(1'b1, 1'b1, OP_MTHI, 32'hDEAD, '0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // MULT -3 x 5, with start/MTLO while busy ignored
        cycle(1'b0, 1'b1, OP_MULT, -32'd3, 32'd5);
        cycle(1'b0, 1'b1, OP_MTLO, 32'h1, '0);
        idle(MC - 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF x 2, changing operands while busy
        cycle(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(MC);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        cycle(1'b0, 1'b1, OP_DIV, -32'd7, 32'd2);
        idle(DC);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // most-negative / -1
        cycle(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // divide by zero keeps hi/lo
        cycle(1'b0, 1'b1, OP_MTHI, 32'h1234, '0);
        cycle(1'b0, 1'b1, OP_MTLO, 32'h5678, '0);
        check("mt_busy", {31'd0, busy}, 32'd0);
        cycle(1'b0, 1'b1, OP_DIV, 32'd99, 32'd0);
        idle(DC);
        check("dz_hi", hi, 32'h1234);
        check("dz_lo", lo, 32'h5678);

        // back-to-back start on the falling edge is dropped, next cycle accepted
        cycle(1'b0, 1'b1, OP_MULTU, 32'd3, 32'd3);
        idle(MC - 1);
        cycle(1'b0, 1'b1, OP_MTHI, 32'hAAAA, '0);
        check("edge_hi", hi, 32'h0);
        cycle(1'b0, 1'b1, OP_MTHI, 32'hBBBB, '0);
        check("next_hi", hi, 32'hBBBB);

        // DIVU 100 / 7 aborted by reset in busy cycle 4
        cycle(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
        idle(3);
        cycle(1'b1, 1'b0, 4'd0, '0, '0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        idle(DC + 2);
        check("abort_late_lo", lo, 32'd0);

        // accumulate (or NONE when the feature is off)
        cycle(1'b0, 1'b1, OP_MTHI, 32'h0, '0);
        cycle(1'b0, 1'b1, OP_MTLO, 32'hA, '0);
        cycle(1'b0, 1'b1, OP_MADD, 32'd2, 32'd3);
        idle(MC);
        check("madd_lo", lo, madd_en() ? 32'h10 : 32'hA);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
        end
        idle(DC + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
